// File: rtl/colormem_writer_pkg.sv
// Shared types for the colour-memory write front end.
// The fill state type is only referenced when COLORMEM_FILL_EN is defined.
package xv;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        CMW_IDLE = 1'b0,
        CMW_RUN  = 1'b1
    } cmw_state_t;

endpackage

// File: rtl/colormem_writer_fifo.sv
// colormem_wr_fifo: synchronous FIFO for queued host palette writes.
// The head entry is visible on pop_data whenever the FIFO is not empty; count, full and empty are registered.
module colormem_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [PW:0]      w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push & ~r_full;
    assign w_pop    = pop & ~r_empty;
    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/colormem_writer.sv
// Colour BRAM write front end: host write queue, optional fill engine, registered write port.
// The fill engine is built only when COLORMEM_FILL_EN is defined.
module colormem_writer
    import xv::*;
#(
    parameter int AWIDTH     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BLANK_ONLY = 0
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic [AWIDTH-1:0] host_addr_i,
    input  logic [15:0]       host_data_i,
    input  logic              blank_i,
    input  logic              fill_start_i,
    input  logic [AWIDTH-1:0] fill_first_i,
    input  logic [AWIDTH-1:0] fill_last_i,
    input  logic [15:0]       fill_data_i,
    output logic              fill_busy_o,
    output logic              fill_state_dbg_o,
    output logic              cm_wr_en_o,
    output logic [AWIDTH-1:0] cm_wr_address_o,
    output logic [15:0]       cm_wr_data_o
);

    // Host handshake: a write is accepted on any edge where host_valid_i and host_ready_o are both high.
    localparam int FW = AWIDTH + WORD_W;

    logic              w_slot;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FW-1:0]     w_head;
    logic              w_fill_req;
    logic              w_fill_grant;
    logic [AWIDTH-1:0] w_fill_addr;
    word_t             w_fill_data;
    logic              r_wr_en;
    logic [AWIDTH-1:0] r_wr_addr;
    word_t             r_wr_data;

    assign w_slot       = (BLANK_ONLY == 0) || blank_i;
    assign host_ready_o = ~w_fifo_full;
    assign w_push       = host_valid_i & ~w_fifo_full;
    assign w_pop        = w_slot & ~w_fifo_empty;
    assign w_fill_grant = w_slot & w_fifo_empty & w_fill_req;

    colormem_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n_i),
        .push      (w_push),
        .push_data ({host_addr_i, host_data_i}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

`ifdef COLORMEM_FILL_EN
    cmw_state_t        r_state;
    cmw_state_t        w_state_nxt;
    logic [AWIDTH-1:0] r_cur;
    logic [AWIDTH-1:0] r_last;
    word_t             r_data;
    logic              r_tail;
    logic              w_start;
    logic              w_at_last;

    // r_tail keeps busy asserted for the cycle in which the final fill write is on the port.
    assign w_start          = fill_start_i && (r_state == CMW_IDLE) && !r_tail;
    assign w_at_last        = (r_cur == r_last);
    assign w_fill_req       = (r_state == CMW_RUN);
    assign w_fill_addr      = r_cur;
    assign w_fill_data      = r_data;
    assign fill_busy_o      = (r_state == CMW_RUN) || r_tail;
    assign fill_state_dbg_o = (r_state == CMW_RUN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CMW_IDLE: if (w_start) w_state_nxt = CMW_RUN;
            CMW_RUN:  if (w_fill_grant && w_at_last) w_state_nxt = CMW_IDLE;
            default:  w_state_nxt = CMW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= CMW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cur  <= '0;
            r_last <= '0;
            r_data <= '0;
            r_tail <= 1'b0;
        end else begin
            r_tail <= w_fill_grant && w_at_last;
            if (w_start) begin
                r_cur  <= fill_first_i;
                r_last <= fill_last_i;
                r_data <= fill_data_i;
            end else if (w_fill_grant && !w_at_last) begin
                r_cur <= r_cur + 1'b1;
            end
        end
    end
`else
    logic w_unused_fill;

    assign w_unused_fill    = ^{fill_start_i, fill_first_i, fill_last_i, fill_data_i};
    assign w_fill_req       = 1'b0;
    assign w_fill_addr      = '0;
    assign w_fill_data      = '0;
    assign fill_busy_o      = 1'b0;
    assign fill_state_dbg_o = 1'b0;
`endif

    // Queued host writes always take the slot ahead of the fill engine.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pop | w_fill_grant;
            if (w_pop) begin
                r_wr_addr <= w_head[FW-1:WORD_W];
                r_wr_data <= w_head[WORD_W-1:0];
            end else if (w_fill_grant) begin
                r_wr_addr <= w_fill_addr;
                r_wr_data <= w_fill_data;
            end
        end
    end

    assign cm_wr_en_o      = r_wr_en;
    assign cm_wr_address_o = r_wr_addr;
    assign cm_wr_data_o    = r_wr_data;

endmodule
